// File: rtl/addsub8_arbiter_pkg.sv
// Shared definitions for the two-requester arbiter around the 8-bit adder/subtractor.
package addsub8_arbiter_pkg;
  localparam int unsigned DATA_W = 8;

  typedef enum logic {
    REQ_EXP_DIFF = 1'b0,
    REQ_EXP_ADJ  = 1'b1
  } req_idx_e;

  localparam req_idx_e PTR_RST = REQ_EXP_DIFF;
endpackage

// File: rtl/addsub8_arbiter_adder.sv
// 8-bit ripple-carry adder/subtractor; subtraction is A + ~B + 1 with Cin tied to e_Sub.
module Adder_Subtractor8
  import addsub8_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              e_Sub,
  output logic [DATA_W-1:0] Sum,
  output logic              Cout
);
  logic [DATA_W-1:0] w_bx;
  logic [DATA_W:0]   w_c;

  assign w_bx = B ^ {DATA_W{e_Sub}};

  always_comb begin
    w_c    = '0;
    Sum    = '0;
    w_c[0] = e_Sub;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      Sum[i]   = A[i] ^ w_bx[i] ^ w_c[i];
      w_c[i+1] = (A[i] & w_bx[i]) | (w_c[i] & (A[i] ^ w_bx[i]));
    end
  end

  assign Cout = w_c[DATA_W];
endmodule

// File: rtl/addsub8_arbiter.sv
// Round-robin sharing of one Adder_Subtractor8 between two requesters, each with a
// one-entry registered response slot and a saturating grant counter.
module addsub8_arbiter
  import addsub8_arbiter_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req0_sub,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_sum,
  output logic              rsp0_cout,
  output logic              rsp0_zero,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic              req1_sub,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_sum,
  output logic              rsp1_cout,
  output logic              rsp1_zero,
  output logic [CNT_W-1:0]  gnt_cnt0,
  output logic [CNT_W-1:0]  gnt_cnt1
);
  req_idx_e          r_ptr, w_ptr_nxt;
  logic              w_elig0, w_elig1, w_gnt0, w_gnt1;
  logic [DATA_W-1:0] w_a, w_b, w_sum;
  logic              w_sub, w_cout;

  logic              r_rsp0_valid, r_rsp0_cout, r_rsp0_zero;
  logic              r_rsp1_valid, r_rsp1_cout, r_rsp1_zero;
  logic [DATA_W-1:0] r_rsp0_sum, r_rsp1_sum;
  logic [CNT_W-1:0]  r_cnt0, r_cnt1;

  // A slot can accept when empty or being drained this same cycle.
  assign w_elig0 = rst_n && req0_valid && (!r_rsp0_valid || rsp0_ready);
  assign w_elig1 = rst_n && req1_valid && (!r_rsp1_valid || rsp1_ready);

  always_comb begin
    w_gnt0    = 1'b0;
    w_gnt1    = 1'b0;
    w_ptr_nxt = r_ptr;
    w_a       = '0;
    w_b       = '0;
    w_sub     = 1'b0;
    if (w_elig0 && (!w_elig1 || r_ptr == REQ_EXP_DIFF)) begin
      w_gnt0    = 1'b1;
      w_ptr_nxt = REQ_EXP_ADJ;
      w_a       = req0_a;
      w_b       = req0_b;
      w_sub     = req0_sub;
    end else if (w_elig1) begin
      w_gnt1    = 1'b1;
      w_ptr_nxt = REQ_EXP_DIFF;
      w_a       = req1_a;
      w_b       = req1_b;
      w_sub     = req1_sub;
    end
  end

  Adder_Subtractor8 u_addsub (
    .A     (w_a),
    .B     (w_b),
    .e_Sub (w_sub),
    .Sum   (w_sum),
    .Cout  (w_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_ptr <= PTR_RST;
    else        r_ptr <= w_ptr_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp0_valid <= 1'b0;
      r_rsp0_sum   <= '0;
      r_rsp0_cout  <= 1'b0;
      r_rsp0_zero  <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp1_sum   <= '0;
      r_rsp1_cout  <= 1'b0;
      r_rsp1_zero  <= 1'b0;
      r_cnt0       <= '0;
      r_cnt1       <= '0;
    end else begin
      if (w_gnt0) begin
        r_rsp0_valid <= 1'b1;
        r_rsp0_sum   <= w_sum;
        r_rsp0_cout  <= w_cout;
        r_rsp0_zero  <= (w_sum == '0);
      end else if (rsp0_ready) begin
        r_rsp0_valid <= 1'b0;
      end
      if (w_gnt1) begin
        r_rsp1_valid <= 1'b1;
        r_rsp1_sum   <= w_sum;
        r_rsp1_cout  <= w_cout;
        r_rsp1_zero  <= (w_sum == '0);
      end else if (rsp1_ready) begin
        r_rsp1_valid <= 1'b0;
      end
      if (w_gnt0 && r_cnt0 != '1) r_cnt0 <= r_cnt0 + 1'b1;
      if (w_gnt1 && r_cnt1 != '1) r_cnt1 <= r_cnt1 + 1'b1;
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign rsp0_valid = r_rsp0_valid;
  assign rsp0_sum   = r_rsp0_sum;
  assign rsp0_cout  = r_rsp0_cout;
  assign rsp0_zero  = r_rsp0_zero;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp1_sum   = r_rsp1_sum;
  assign rsp1_cout  = r_rsp1_cout;
  assign rsp1_zero  = r_rsp1_zero;
  assign gnt_cnt0   = r_cnt0;
  assign gnt_cnt1   = r_cnt1;
endmodule
